// File: rtl/rs_chien_sched_if.sv
// Descriptor, batch-issue, hit-return and result signals of the Chien search scheduler.
// The scheduler takes the slave side; the BM stage, evaluator and correction stage take master.
interface rs_chien_sched_if #(
    parameter int SYMB_WIDTH      = 8,
    parameter int T_LEN           = 8,
    parameter int ROOTS_NUM       = 255,
    parameter int ROOTS_PER_CYCLE = 16
) ();
    localparam int DEG_W = $clog2(T_LEN + 1);
    localparam int CNT_W = $clog2(ROOTS_NUM + 1);

    logic                       loc_vld;
    logic                       loc_rdy;
    logic [DEG_W-1:0]           loc_deg;
    logic                       issue_vld;
    logic [SYMB_WIDTH-1:0]      issue_base;
    logic                       issue_last;
    logic [ROOTS_PER_CYCLE-1:0] issue_mask;
    logic                       hit_vld;
    logic [ROOTS_PER_CYCLE-1:0] hit_vect;
    logic                       res_vld;
    logic                       res_rdy;
    logic [CNT_W-1:0]           res_cnt;
    logic                       res_fail;

    modport master (
        output loc_vld, loc_deg, hit_vld, hit_vect, res_rdy,
        input  loc_rdy, issue_vld, issue_base, issue_last, issue_mask,
               res_vld, res_cnt, res_fail
    );

    modport slave (
        input  loc_vld, loc_deg, hit_vld, hit_vect, res_rdy,
        output loc_rdy, issue_vld, issue_base, issue_last, issue_mask,
               res_vld, res_cnt, res_fail
    );
endinterface

// File: rtl/rs_chien_sched.sv
// Chien search sequencer: issues root batches to the evaluator lanes, counts the
// returned roots and reports the count plus a decode-failure flag.
module rs_chien_sched #(
    parameter int SYMB_WIDTH      = 8,
    parameter int T_LEN           = 8,
    parameter int ROOTS_NUM       = 255,
    parameter int ROOTS_PER_CYCLE = 16
) (
    input logic             aclk,
    input logic             aresetn,
    rs_chien_sched_if.slave bus
);
    localparam int CYCLES    = (ROOTS_NUM + ROOTS_PER_CYCLE - 1) / ROOTS_PER_CYCLE;
    localparam int NON_VALID = ROOTS_NUM % ROOTS_PER_CYCLE;
    localparam int DEG_W     = $clog2(T_LEN + 1);
    localparam int CNT_W     = $clog2(ROOTS_NUM + 1);
    localparam int CYC_W     = $clog2(CYCLES + 1);

    localparam logic [ROOTS_PER_CYCLE-1:0] ALL_ONES  = '1;
    localparam logic [ROOTS_PER_CYCLE-1:0] LAST_MASK = (NON_VALID != 0) ?
        (ALL_ONES >> (ROOTS_PER_CYCLE - NON_VALID)) : ALL_ONES;
    localparam logic [CYC_W-1:0] LAST_K  = CYC_W'(CYCLES - 1);
    localparam logic [CYC_W-1:0] CYC_END = CYC_W'(CYCLES);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RESULT} state_t;

    state_t                state, state_nxt;
    logic [DEG_W-1:0]      deg_q;
    logic [CYC_W-1:0]      issue_k;
    logic [CYC_W-1:0]      ret_k;
    logic [SYMB_WIDTH-1:0] base_q;
    logic [CNT_W-1:0]      acc;
    logic                  accept;
    logic                  hit_take;
    logic                  ret_done;

    function automatic logic [CNT_W-1:0] popcount(input logic [ROOTS_PER_CYCLE-1:0] v);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < ROOTS_PER_CYCLE; i++)
            n = n + CNT_W'(v[i]);
        return n;
    endfunction

    assign accept   = (state == IDLE) && bus.loc_vld;
    assign hit_take = bus.hit_vld && ((state == ISSUE) || (state == DRAIN));
    // Counts the return arriving this cycle, so a final hit coinciding with the last issue closes the search.
    assign ret_done = (ret_k + CYC_W'(hit_take)) == CYC_END;

    assign bus.issue_base = base_q;
    assign bus.res_cnt    = acc;
    assign bus.res_fail   = (state == RESULT) && (acc != CNT_W'(deg_q));

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        bus.loc_rdy    = 1'b0;
        bus.issue_vld  = 1'b0;
        bus.issue_last = 1'b0;
        bus.issue_mask = '0;
        bus.res_vld    = 1'b0;
        case (state)
            IDLE: begin
                bus.loc_rdy = 1'b1;
                if (bus.loc_vld) begin
                    if ((bus.loc_deg == '0) || (bus.loc_deg > DEG_W'(T_LEN)))
                        state_nxt = RESULT;
                    else
                        state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                bus.issue_vld  = 1'b1;
                bus.issue_last = (issue_k == LAST_K);
                bus.issue_mask = (issue_k == LAST_K) ? LAST_MASK : ALL_ONES;
                if (issue_k == LAST_K)
                    state_nxt = ret_done ? RESULT : DRAIN;
            end
            DRAIN: begin
                if (ret_done)
                    state_nxt = RESULT;
            end
            RESULT: begin
                bus.res_vld = 1'b1;
                if (bus.res_rdy)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            deg_q   <= '0;
            issue_k <= '0;
            ret_k   <= '0;
            base_q  <= '0;
            acc     <= '0;
        end else if (accept) begin
            deg_q   <= bus.loc_deg;
            issue_k <= '0;
            ret_k   <= '0;
            base_q  <= '0;
            acc     <= '0;
        end else begin
            if (state == ISSUE) begin
                issue_k <= issue_k + CYC_W'(1);
                base_q  <= base_q + SYMB_WIDTH'(ROOTS_PER_CYCLE);
            end
            // Returns come back in issue order, so the CYCLES-th return is the short batch.
            if (hit_take) begin
                ret_k <= ret_k + CYC_W'(1);
                acc   <= acc + popcount(bus.hit_vect & ((ret_k == LAST_K) ? LAST_MASK : ALL_ONES));
            end
        end
    end
endmodule

// File: tb/tb_rs_chien_sched.sv
// Directed bench for rs_chien_sched with a latency-programmable evaluator model.
module tb_rs_chien_sched;
    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    rs_chien_sched_if bus ();

    rs_chien_sched dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .bus     (bus)
    );

    int          nvec = 0;
    int          nfail = 0;
    logic [15:0] tab [16];
    int          lat = 2;
    logic        stray = 1'b0;
    logic [16:0] pend [8];

    // Evaluator model: the batch seen at negedge j returns its table entry at negedge j+lat.
    initial begin
        for (int i = 0; i < 8; i++) pend[i] = '0;
        bus.hit_vld  = 1'b0;
        bus.hit_vect = '0;
        forever begin
            @(negedge aclk);
            if (bus.issue_vld === 1'b1)
                pend[lat] = {1'b1, tab[bus.issue_base[7:4]]};
            bus.hit_vld  = pend[0][16] | stray;
            bus.hit_vect = stray ? 16'hFFFF : pend[0][15:0];
            for (int i = 0; i < 7; i++) pend[i] = pend[i+1];
            pend[7] = '0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic clear_tab();
        for (int i = 0; i < 16; i++) tab[i] = 16'h0000;
    endtask

    task automatic send(input logic [3:0] deg);
        bus.loc_vld = 1'b1;
        bus.loc_deg = deg;
        @(negedge aclk);
        bus.loc_vld = 1'b0;
    endtask

    task automatic take_res();
        bus.res_rdy = 1'b1;
        @(negedge aclk);
        bus.res_rdy = 1'b0;
    endtask

    // Advances from cycle j0 until res_vld; j = cycle index, or -1 on timeout.
    task automatic wait_res(input int j0, output int j);
        j = j0;
        while (bus.res_vld !== 1'b1 && j < j0 + 60) begin
            @(negedge aclk);
            j++;
        end
        if (bus.res_vld !== 1'b1) j = -1;
    endtask

    task automatic test_reset();
        logic [36:0] got;
        @(negedge aclk);
        @(negedge aclk);
        got = {bus.loc_rdy, bus.issue_vld, bus.issue_base, bus.issue_last, bus.issue_mask,
               bus.res_vld, bus.res_cnt, bus.res_fail};
        nvec++;
        if (got !== {1'b1, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0}) begin
            nfail++;
            $display("FAIL reset_outputs got %h required %h", got, 37'h10_0000_0000);
        end
        aresetn = 1'b1;
        @(negedge aclk);
        nvec++;
        if (bus.loc_rdy !== 1'b1 || bus.res_vld !== 1'b0) begin
            nfail++;
            $display("FAIL reset_release loc_rdy=%b res_vld=%b required 1 0", bus.loc_rdy, bus.res_vld);
        end
    endtask

    task automatic test_nominal();
        logic [25:0] got, exp;
        int j;
        lat = 2;
        clear_tab();
        tab[0]  = 16'h0020;
        tab[2]  = 16'h0100;
        tab[12] = 16'h0100;
        nvec++;
        if (bus.loc_rdy !== 1'b1) begin
            nfail++;
            $display("FAIL nom_loc_rdy got %b required 1", bus.loc_rdy);
        end
        send(4'd3);
        for (int k = 0; k < 16; k++) begin
            got = {bus.issue_vld, bus.issue_base, bus.issue_last, bus.issue_mask};
            exp = {1'b1, 8'(k * 16), (k == 15), (k == 15) ? 16'h7FFF : 16'hFFFF};
            nvec++;
            if (got !== exp) begin
                nfail++;
                $display("FAIL nom_issue batch %0d got %h required %h", k, got, exp);
            end
            @(negedge aclk);
        end
        nvec++;
        if (bus.issue_vld !== 1'b0 || bus.loc_rdy !== 1'b0) begin
            nfail++;
            $display("FAIL nom_after_issue issue_vld=%b loc_rdy=%b required 0 0", bus.issue_vld, bus.loc_rdy);
        end
        wait_res(17, j);
        nvec++;
        if (j !== 19) begin
            nfail++;
            $display("FAIL nom_latency got %0d required 19", j);
        end
        nvec++;
        if ({bus.res_cnt, bus.res_fail} !== {8'd3, 1'b0}) begin
            nfail++;
            $display("FAIL nom_result cnt=%0d fail=%b required 3 0", bus.res_cnt, bus.res_fail);
        end
        take_res();
        nvec++;
        if (bus.res_vld !== 1'b0 || bus.loc_rdy !== 1'b1) begin
            nfail++;
            $display("FAIL nom_release res_vld=%b loc_rdy=%b required 0 1", bus.res_vld, bus.loc_rdy);
        end
    endtask

    task automatic test_last_mask();
        int j;
        lat = 2;
        clear_tab();
        tab[2]  = 16'h0010;
        tab[15] = 16'h8000;
        send(4'd2);
        wait_res(1, j);
        nvec++;
        if (j !== 19 || {bus.res_cnt, bus.res_fail} !== {8'd1, 1'b1}) begin
            nfail++;
            $display("FAIL mask_result at=%0d cnt=%0d fail=%b required 19 1 1", j, bus.res_cnt, bus.res_fail);
        end
        take_res();
    endtask

    task automatic test_zero_latency();
        int j;
        lat = 0;
        clear_tab();
        tab[15] = 16'h4000;
        send(4'd1);
        wait_res(1, j);
        nvec++;
        if (j !== 17 || {bus.res_cnt, bus.res_fail} !== {8'd1, 1'b0}) begin
            nfail++;
            $display("FAIL zlat_result at=%0d cnt=%0d fail=%b required 17 1 0", j, bus.res_cnt, bus.res_fail);
        end
        take_res();
        lat = 2;
    endtask

    task automatic test_degree_edges();
        logic [10:0] got;
        int j;
        clear_tab();
        send(4'd0);
        got = {bus.issue_vld, bus.res_vld, bus.res_cnt, bus.res_fail};
        nvec++;
        if (got !== {1'b0, 1'b1, 8'd0, 1'b0}) begin
            nfail++;
            $display("FAIL deg0_result got %h required %h", got, {1'b0, 1'b1, 8'd0, 1'b0});
        end
        take_res();
        send(4'd9);
        got = {bus.issue_vld, bus.res_vld, bus.res_cnt, bus.res_fail};
        nvec++;
        if (got !== {1'b0, 1'b1, 8'd0, 1'b1}) begin
            nfail++;
            $display("FAIL deg9_result got %h required %h", got, {1'b0, 1'b1, 8'd0, 1'b1});
        end
        take_res();
        send(4'd8);
        nvec++;
        if (bus.issue_vld !== 1'b1 || bus.res_vld !== 1'b0) begin
            nfail++;
            $display("FAIL deg8_issue issue_vld=%b res_vld=%b required 1 0", bus.issue_vld, bus.res_vld);
        end
        wait_res(1, j);
        nvec++;
        if (j !== 19 || {bus.res_cnt, bus.res_fail} !== {8'd0, 1'b1}) begin
            nfail++;
            $display("FAIL deg8_result at=%0d cnt=%0d fail=%b required 19 0 1", j, bus.res_cnt, bus.res_fail);
        end
        take_res();
    endtask

    task automatic test_backpressure();
        int j;
        lat = 2;
        clear_tab();
        tab[0] = 16'h0003;
        send(4'd3);
        wait_res(1, j);
        nvec++;
        if (j !== 19) begin
            nfail++;
            $display("FAIL hold_latency got %0d required 19", j);
        end
        for (int i = 0; i < 5; i++) begin
            bus.loc_vld = (i % 2 == 0);
            bus.loc_deg = 4'd1;
            @(negedge aclk);
            nvec++;
            if ({bus.res_vld, bus.res_cnt, bus.res_fail, bus.loc_rdy} !== {1'b1, 8'd2, 1'b1, 1'b0}) begin
                nfail++;
                $display("FAIL hold_stable cycle %0d vld=%b cnt=%0d fail=%b loc_rdy=%b required 1 2 1 0",
                         i, bus.res_vld, bus.res_cnt, bus.res_fail, bus.loc_rdy);
            end
        end
        clear_tab();
        tab[1] = 16'h0001;
        bus.loc_vld = 1'b1;
        bus.loc_deg = 4'd1;
        bus.res_rdy = 1'b1;
        @(negedge aclk);
        bus.res_rdy = 1'b0;
        nvec++;
        if (bus.loc_rdy !== 1'b1 || bus.res_vld !== 1'b0) begin
            nfail++;
            $display("FAIL hold_reaccept loc_rdy=%b res_vld=%b required 1 0", bus.loc_rdy, bus.res_vld);
        end
        @(negedge aclk);
        bus.loc_vld = 1'b0;
        nvec++;
        if (bus.issue_vld !== 1'b1 || bus.issue_base !== 8'd0) begin
            nfail++;
            $display("FAIL hold_next_issue vld=%b base=%0d required 1 0", bus.issue_vld, bus.issue_base);
        end
        wait_res(1, j);
        nvec++;
        if (j !== 19 || {bus.res_cnt, bus.res_fail} !== {8'd1, 1'b0}) begin
            nfail++;
            $display("FAIL hold_next_result at=%0d cnt=%0d fail=%b required 19 1 0", j, bus.res_cnt, bus.res_fail);
        end
        take_res();
    endtask

    task automatic test_reset_mid();
        logic [36:0] got;
        int j;
        lat = 2;
        for (int i = 0; i < 16; i++) tab[i] = 16'hFFFF;
        send(4'd3);
        repeat (7) @(negedge aclk);
        nvec++;
        if (bus.issue_vld !== 1'b1 || bus.issue_base !== 8'd112) begin
            nfail++;
            $display("FAIL rst_batch7 vld=%b base=%0d required 1 112", bus.issue_vld, bus.issue_base);
        end
        aresetn = 1'b0;
        #1;
        got = {bus.loc_rdy, bus.issue_vld, bus.issue_base, bus.issue_last, bus.issue_mask,
               bus.res_vld, bus.res_cnt, bus.res_fail};
        nvec++;
        if (got !== {1'b1, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0}) begin
            nfail++;
            $display("FAIL rst_mid_outputs got %h required %h", got, 37'h10_0000_0000);
        end
        @(negedge aclk);
        aresetn = 1'b1;
        stray = 1'b1;
        repeat (4) @(negedge aclk);
        stray = 1'b0;
        nvec++;
        if (bus.loc_rdy !== 1'b1 || bus.issue_vld !== 1'b0 || bus.res_vld !== 1'b0) begin
            nfail++;
            $display("FAIL rst_stray_idle loc_rdy=%b issue_vld=%b res_vld=%b required 1 0 0",
                     bus.loc_rdy, bus.issue_vld, bus.res_vld);
        end
        repeat (3) @(negedge aclk);
        clear_tab();
        tab[4] = 16'h0200;
        send(4'd1);
        wait_res(1, j);
        nvec++;
        if (j !== 19 || {bus.res_cnt, bus.res_fail} !== {8'd1, 1'b0}) begin
            nfail++;
            $display("FAIL rst_fresh_run at=%0d cnt=%0d fail=%b required 19 1 0", j, bus.res_cnt, bus.res_fail);
        end
        take_res();
    endtask

    initial begin
        bus.loc_vld = 1'b0;
        bus.loc_deg = '0;
        bus.res_rdy = 1'b0;
        for (int i = 0; i < 16; i++) tab[i] = 16'h0000;
        test_reset();
        test_nominal();
        test_last_mask();
        test_zero_latency();
        test_degree_edges();
        test_backpressure();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
